// File: rtl/data_mem_unit.sv
// data_mem_unit: zero-wait-state data memory with word RAM and a 16-byte MMIO window (GPIO, timer, status)
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   load, store        MEM-stage access requests (both high = store, data_out shows pre-write value)
//   address, data_in   byte address and store data (word accesses only)
//   data_out           combinational read data, 0 when idle, unmapped or misaligned
//   gpio_out           registered GPIO output
//   timer_irq          STATUS bit0 (timer_match)
module data_mem_unit #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);
  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_gpio, r_count, r_compare;
  logic [1:0]  r_status;
  logic [31:0] w_off, w_reg_rd;
  logic [AW-1:0] w_idx;
  logic [1:0]  w_reg, w_clr;
  logic        w_aligned, w_ram_hit, w_mmio_hit, w_bad, w_match, w_wr;
  assign w_aligned  = address[1:0] == 2'b00;
  assign w_off      = address - MMIO_BASE;
  assign w_idx      = address[AW+1:2];
  assign w_reg      = w_off[3:2];
  assign w_ram_hit  = w_aligned && address < RAM_BYTES;
  // unsigned offset test covers the window without overflow at the top of the map
  assign w_mmio_hit = w_aligned && !w_ram_hit && w_off < 32'd16;
  assign w_bad      = (load || store) && !(w_ram_hit || w_mmio_hit);
  assign w_match    = r_count == r_compare && r_compare != 32'd0;
  assign w_wr       = store && !reset;
  assign w_clr      = (w_wr && w_mmio_hit && w_reg == 2'd3) ? data_in[1:0] : 2'b00;
  always_comb begin
    w_reg_rd = w_reg == 2'd0 ? r_gpio :
               w_reg == 2'd1 ? r_count :
               w_reg == 2'd2 ? r_compare : {30'b0, r_status};
    data_out = !load                  ? 32'd0 :
               w_ram_hit              ? r_ram[w_idx] :
               (w_mmio_hit && !reset) ? w_reg_rd : 32'd0;
  end
  always_ff @(posedge clk)
    if (w_wr && w_ram_hit) r_ram[w_idx] <= data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio    <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_status  <= '0;
    end else begin
      r_gpio    <= (w_wr && w_mmio_hit && w_reg == 2'd0) ? data_in : r_gpio;
      r_count   <= (w_wr && w_mmio_hit && w_reg == 2'd1) ? data_in : r_count + 32'd1;
      r_compare <= (w_wr && w_mmio_hit && w_reg == 2'd2) ? data_in : r_compare;
      // set events are ORed after the clear so a coincident set survives
      r_status  <= (r_status & ~w_clr) | {w_bad, w_match};
    end
  end
  assign gpio_out  = r_gpio;
  assign timer_irq = r_status[0];
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: scoreboard bench with a behavioural model for data_mem_unit
module tb_data_mem_unit;
  localparam logic [31:0] MB = 32'h0000_7F00;
  logic clk = 0, reset = 0, load = 0, store = 0;
  logic [31:0] address = 0, data_in = 0;
  logic [31:0] data_out, gpio_out;
  logic timer_irq;
  data_mem_unit #(.RAM_WORDS(1024), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .load(load), .store(store), .address(address),
    .data_in(data_in), .data_out(data_out), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        chk_out;
    logic [31:0] out;
    logic [31:0] gpio;
    logic        irq;
    int          tag;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, tag = 0;
  bit known = 0;
  logic [31:0] m_ram [int];
  logic [31:0] m_gpio, m_count, m_compare;
  bit m_match, m_bad;
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk_out) begin
        vectors++;
        if (data_out !== e.out) begin
          miscompares++;
          $display("FAIL data_out tag%0d: got %h want %h", e.tag, data_out, e.out);
        end
      end
      vectors++;
      if (gpio_out !== e.gpio) begin
        miscompares++;
        $display("FAIL gpio_out tag%0d: got %h want %h", e.tag, gpio_out, e.gpio);
      end
      vectors++;
      if (timer_irq !== e.irq) begin
        miscompares++;
        $display("FAIL timer_irq tag%0d: got %b want %b", e.tag, timer_irq, e.irq);
      end
    end
  function automatic logic [31:0] reg_rd(input int r);
    return r == 0 ? m_gpio : r == 1 ? m_count : r == 2 ? m_compare : {30'b0, m_bad, m_match};
  endfunction
  task automatic cyc(input logic r, l, s, input logic [31:0] a, d);
    exp_t e;
    logic [31:0] off, nc;
    bit ram_hit, mmio_hit, bad_ev, match_ev;
    int w;
    reset = r; load = l; store = s; address = a; data_in = d;
    off = a - MB;
    w = int'(a >> 2);
    ram_hit  = a % 4 == 0 && a < 4096;
    mmio_hit = a % 4 == 0 && !ram_hit && off < 16;
    e.chk_out = 1; e.out = 0; e.tag = tag;
    if (l && ram_hit) begin
      if (m_ram.exists(w)) e.out = m_ram[w];
      else e.chk_out = 0;
    end else if (l && mmio_hit && !r) e.out = reg_rd(int'(off / 4));
    e.gpio = m_gpio; e.irq = m_match;
    if (known) q.push_back(e);
    if (r) begin
      m_gpio = 0; m_count = 0; m_compare = 0; m_match = 0; m_bad = 0; known = 1;
    end else begin
      bad_ev   = (l || s) && !(ram_hit || mmio_hit);
      match_ev = m_count == m_compare && m_compare != 0;
      nc = m_count + 1;
      if (s && ram_hit) m_ram[w] = d;
      if (s && mmio_hit)
        case (off / 4)
          0: m_gpio = d;
          1: nc = d;
          2: m_compare = d;
          default: begin
            if (d[0]) m_match = 0;
            if (d[1]) m_bad = 0;
          end
        endcase
      m_count = nc;
      m_match = m_match | match_ev;
      m_bad   = m_bad | bad_ev;
    end
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] a, d;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(1);
    tag = 30;
    cyc(0, 0, 1, 32'h10, 32'h1234_5678);
    cyc(0, 1, 0, 32'h10, 0);
    cyc(0, 0, 1, 32'h14, 0);
    cyc(0, 1, 0, 32'h14, 0);
    tag = 31;
    cyc(0, 0, 1, 32'h20, 32'hAAAA_AAAA);
    cyc(0, 1, 1, 32'h20, 32'h5555_5555);
    cyc(0, 1, 0, 32'h20, 0);
    tag = 32;
    cyc(0, 0, 1, MB + 8, 10);
    cyc(0, 0, 1, MB + 4, 5);
    idle(8);
    cyc(0, 0, 1, MB + 12, 1);
    idle(2);
    tag = 33;
    cyc(0, 0, 1, MB + 8, 0);
    cyc(0, 0, 1, MB + 4, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, MB + 4, 0);
    tag = 34;
    cyc(0, 1, 0, 32'h6, 0);
    cyc(0, 0, 1, 32'h9000, 32'hDEAD_BEEF);
    cyc(0, 1, 0, MB + 12, 0);
    cyc(0, 0, 1, MB + 8, 100);
    cyc(0, 0, 1, MB + 4, 100);
    cyc(0, 0, 1, MB + 12, 3);
    cyc(0, 1, 0, MB + 12, 0);
    tag = 35;
    cyc(0, 0, 1, MB, 32'hFF);
    idle(2);
    cyc(1, 0, 1, MB, 32'h1);
    cyc(0, 1, 0, MB + 4, 0);
    cyc(0, 1, 0, MB + 4, 0);
    cyc(0, 1, 0, 32'h10, 0);
    tag = 99;
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 9);
      a = k < 5 ? $urandom_range(0, 15) * 4 :
          k < 8 ? MB + $urandom_range(0, 3) * 4 :
          k == 8 ? 32'h6 : (($urandom_range(0, 1) == 1) ? MB + 16 : 32'h1000);
      d = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 40)) : $urandom;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a, d);
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
